mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of WAIT cycles without mem_ack before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port OpCode, input, 5, the opcode from the EX/MEM register.
REQ-005 SHALL have port RdOut, input, 9, the destination tag from EX/MEM, treated as opaque.
REQ-006 SHALL have port AluResult, input, 32, the ALU result, used as memory address for load/store.
REQ-007 SHALL have port StoreData, input, 32, the write data for STORE.
REQ-008 SHALL have port stall, output, 1, combinational; upstream SHALL hold its inputs while it is 1.
REQ-009 SHALL have ports mem_req, mem_we (output, 1 each), mem_addr and mem_wdata (output, 32 each), forming the data-memory request.
REQ-010 SHALL have ports mem_ack (input, 1) and mem_rdata (input, 32), forming the data-memory response.
REQ-011 SHALL have ports OpCodeOut (output, 5), RdOutOut (output, 9) and ResultOut (output, 32), all registered, forming the MEM/WB payload.
REQ-012 SHALL have port err, output, 1, a sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT.
REQ-014 SHALL treat OpCode==OP_LOAD (5'b01010) or OpCode==OP_STORE (5'b01011) as a memory op; all other opcodes are non-memory.
REQ-015 In IDLE with a non-memory op, at posedge: OpCodeOut<=OpCode, RdOutOut<=RdOut, ResultOut<=AluResult (latency 1); stall=0.
REQ-016 In IDLE with a memory op: stall=1 and mem_req=0; at posedge: capture address/data/we/opcode/rd, go to WAIT, clear timeout counter, emit bubble.
REQ-017 A bubble SHALL set OpCodeOut=OP_NOP (5'b00000), RdOutOut=0 and ResultOut=0.
REQ-018 In WAIT: mem_req=1; mem_addr, mem_wdata and mem_we SHALL be driven from the captured values and held stable until ack.
REQ-019 In WAIT without ack: stall=1, counter increments, and a bubble is emitted.
REQ-020 In WAIT with mem_ack=1: stall=0; at posedge: go to IDLE; LOAD emits ResultOut<=mem_rdata with captured opcode/rd; STORE emits ResultOut<=captured address with captured opcode/rd.
REQ-021 Best-case memory-op latency SHALL be 2 cycles from acceptance in IDLE to the MEM/WB update.
REQ-022 If the counter reaches TIMEOUT-1 in WAIT without ack: at posedge, err<=1, state goes to IDLE, and a bubble is emitted; stall drops in that same cycle.
REQ-023 mem_ack in IDLE SHALL be ignored.
REQ-024 If mem_ack coincides with the timeout cycle, the ack SHALL win and err SHALL remain unchanged.
REQ-025 The counter SHALL be clog2(TIMEOUT) bits and SHALL never wrap past TIMEOUT-1.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, counter=0, err=0, OpCodeOut=OP_NOP, RdOutOut=0, ResultOut=0, and captured registers=0.
REQ-028 While in reset, mem_req=0 and stall=0.
REQ-029 Reset asserted mid-WAIT SHALL abandon the request with no MEM/WB update; the memory side SHALL tolerate req dropping.

Structure
REQ-030 A shared package mem_pkg SHALL hold OP_NOP, OP_LOAD, OP_STORE, the state enum type, and the default TIMEOUT constant.
REQ-031 There SHALL be no sub-module; the FSM, counter and output register SHALL reside in mem_stage.

Verification
REQ-032 Non-memory op: OpCode=5'b00001, RdOut=9'h0A5, AluResult=32'h1234 -> next posedge OpCodeOut=5'b00001, RdOutOut=9'h0A5, ResultOut=32'h1234, stall=0 throughout.
REQ-033 LOAD: AluResult=32'h40, ack 1 cycle into WAIT, mem_rdata=32'hDEADBEEF -> mem_addr=32'h40 and mem_we=0 during WAIT; ResultOut=32'hDEADBEEF two cycles after accept; stall high for exactly 2 cycles.
REQ-034 STORE: StoreData=32'hCAFE, ack after 3 WAIT cycles -> mem_we=1 and mem_wdata=32'hCAFE held 3 cycles; bubbles during WAIT; err=0.
REQ-035 Timeout: LOAD, no ack -> mem_req high 16 cycles, then err=1, bubble emitted, state IDLE; a following non-memory op completes normally and err stays 1.
REQ-036 Ack on the 16th WAIT cycle -> normal completion, err=0.
REQ-037 rst pulse mid-WAIT -> outputs immediately OP_NOP/0, mem_req=0, err=0; no MEM/WB update from the abandoned op.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared opcodes, FSM state type and default timeout for the MEM stage
package mem_pkg;
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_LOAD = 5'b01010;
  localparam logic [4:0] OP_STORE = 5'b01011;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage issuing load/store requests and writing the MEM/WB register
// ports: clk/rst (async high); OpCode/RdOut/AluResult/StoreData from EX/MEM; stall upstream hold;
//        mem_req/mem_we/mem_addr/mem_wdata request, mem_ack/mem_rdata response;
//        OpCodeOut/RdOutOut/ResultOut MEM/WB payload; err sticky timeout flag
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  OpCode,
  input  logic [8:0]  RdOut,
  input  logic [31:0] AluResult,
  input  logic [31:0] StoreData,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  OpCodeOut,
  output logic [8:0]  RdOutOut,
  output logic [31:0] ResultOut,
  output logic        err
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, data_q;
  logic we_q;
  logic [4:0] op_q;
  logic [8:0] rd_q;
  logic is_mem, last;
  assign is_mem = OpCode == OP_LOAD || OpCode == OP_STORE;
  assign last = cnt == LAST;
  assign mem_addr = addr_q;
  assign mem_wdata = data_q;
  assign mem_we = we_q;
  // the timeout cycle releases stall so upstream can move on while we abort
  always_comb begin
    stall = 1'b0;
    mem_req = 1'b0;
    state_n = state;
    if (!rst) begin
      stall = state == IDLE ? is_mem : !mem_ack && !last;
      mem_req = state == WAIT;
      state_n = state == IDLE ? (is_mem ? WAIT : IDLE) : (mem_ack || last ? IDLE : WAIT);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      op_q <= OP_NOP;
      rd_q <= '0;
      OpCodeOut <= OP_NOP;
      RdOutOut <= '0;
      ResultOut <= '0;
    end else begin
      state <= state_n;
      OpCodeOut <= OP_NOP;
      RdOutOut <= '0;
      ResultOut <= '0;
      if (state == IDLE) begin
        cnt <= '0;
        if (is_mem) begin
          addr_q <= AluResult;
          data_q <= StoreData;
          we_q <= OpCode == OP_STORE;
          op_q <= OpCode;
          rd_q <= RdOut;
        end else begin
          OpCodeOut <= OpCode;
          RdOutOut <= RdOut;
          ResultOut <= AluResult;
        end
      end else if (mem_ack) begin
        OpCodeOut <= op_q;
        RdOutOut <= rd_q;
        ResultOut <= we_q ? addr_q : mem_rdata;
      end else if (last) begin
        err <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a transaction-level model
module tb_mem_stage;
  import mem_pkg::*;
  localparam int TO = 16;
  typedef logic [46:0] exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] OpCode = '0;
  logic [8:0] RdOut = '0;
  logic [31:0] AluResult = '0, StoreData = '0, mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic stall, mem_req, mem_we, err;
  logic [31:0] mem_addr, mem_wdata, ResultOut;
  logic [4:0] OpCodeOut;
  logic [8:0] RdOutOut;
  int tests = 0, fails = 0;
  bit mon_en = 1'b0, model_err = 1'b0;
  exp_t q[$];
  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .RdOut(RdOut), .AluResult(AluResult),
    .StoreData(StoreData), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .OpCodeOut(OpCodeOut), .RdOutOut(RdOutOut), .ResultOut(ResultOut), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic push_bubbles(input int n);
    for (int i = 0; i < n; i++) q.push_back({OP_NOP, 9'd0, 32'd0, model_err});
  endtask
  // one MEM/WB record expected per clock edge while the monitor is enabled
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (mon_en && q.size() != 0) begin
        e = q.pop_front();
        @(negedge clk);
        chk("memwb", {17'd0, OpCodeOut, RdOutOut, ResultOut, err}, {17'd0, e});
      end
    end
  end
  // lat = WAIT cycles before ack; lat >= TO means the memory never answers
  task automatic run_txn(input logic [4:0] op, input logic [8:0] rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdata, input int lat);
    bit mem, ack_now;
    mem = op == OP_LOAD || op == OP_STORE;
    @(posedge clk);
    #1;
    OpCode = op;
    RdOut = rd;
    AluResult = a;
    StoreData = d;
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    if (!mem) begin
      q.push_back({op, rd, a, model_err});
      #1 chk("stall_nonmem", {63'd0, stall}, 64'd0);
      return;
    end
    if (lat < TO) begin
      push_bubbles(lat + 1);
      q.push_back({op, rd, op == OP_STORE ? a : rdata, model_err});
    end else begin
      push_bubbles(TO);
      model_err = 1'b1;
      push_bubbles(1);
    end
    #1;
    chk("stall_accept", {63'd0, stall}, 64'd1);
    chk("req_accept", {63'd0, mem_req}, 64'd0);
    for (int c = 1; c <= TO; c++) begin
      @(posedge clk);
      #1;
      ack_now = lat < TO && c == lat + 1;
      mem_ack = ack_now;
      mem_rdata = ack_now ? rdata : $urandom;
      #1;
      chk("req_wait", {63'd0, mem_req}, 64'd1);
      chk("addr_wait", {32'd0, mem_addr}, {32'd0, a});
      chk("we_wait", {63'd0, mem_we}, {63'd0, op == OP_STORE});
      if (op == OP_STORE) chk("wdata_wait", {32'd0, mem_wdata}, {32'd0, d});
      chk("stall_wait", {63'd0, stall}, {63'd0, !ack_now && c != TO});
      if (ack_now) break;
    end
  endtask
  initial begin
    logic [4:0] op;
    int lat;
    OpCode = OP_LOAD;
    #12;
    chk("rst_out", {17'd0, OpCodeOut, RdOutOut, ResultOut, err}, 64'd0);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    OpCode = OP_NOP;
    mon_en = 1'b1;
    run_txn(5'b00001, 9'h0A5, 32'h1234, 32'h0, 32'h0, 0);
    run_txn(OP_LOAD, 9'h011, 32'h40, 32'h0, 32'hDEADBEEF, 1);
    run_txn(OP_STORE, 9'h022, 32'h80, 32'hCAFE, 32'h0, 3);
    run_txn(OP_LOAD, 9'h033, 32'h44, 32'h0, 32'h5555AAAA, 0);
    run_txn(OP_LOAD, 9'h044, 32'h48, 32'h0, 32'h12345678, TO - 1);
    run_txn(OP_STORE, 9'h055, 32'h4C, 32'h9, 32'h0, TO - 1);
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom);
      if ($urandom_range(0, 1) == 1) op = $urandom_range(0, 1) == 1 ? OP_LOAD : OP_STORE;
      lat = $urandom_range(0, 9) == 0 ? TO - 1 : $urandom_range(0, 4);
      run_txn(op, 9'($urandom), $urandom, $urandom, $urandom, lat);
    end
    run_txn(OP_LOAD, 9'h066, 32'h50, 32'h0, 32'h0, 100);
    run_txn(5'b00001, 9'h077, 32'hABCD, 32'h0, 32'h0, 0);
    run_txn(5'b00011, 9'h078, 32'hBCDE, 32'h0, 32'h0, 0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("queue_drained", 64'(q.size()), 64'd0);
    q.delete();
    mem_ack = 1'b0;
    OpCode = OP_LOAD;
    RdOut = 9'h1FF;
    AluResult = 32'h60;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_req", {63'd0, mem_req}, 64'd1);
    chk("pre_rst_err", {63'd0, err}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out", {17'd0, OpCodeOut, RdOutOut, ResultOut, err}, 64'd0);
    chk("midrst_req", {63'd0, mem_req}, 64'd0);
    chk("midrst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    OpCode = 5'b00001;
    RdOut = 9'h0;
    AluResult = 32'h0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("post_rst_out", {17'd0, OpCodeOut, RdOutOut, ResultOut, err}, {17'd0, 5'b00001, 9'd0, 32'd0, 1'b0});
    chk("post_rst_req", {63'd0, mem_req}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
